// File: rtl/sparrow_decode_stage.sv
// Sparrow decode stage: classifies and decodes raw RV32I(+M) instructions and
// buffers decoded entries in a small FIFO between fetch and execute.

package sparrow_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_IMM  = 2'd2;
   localparam logic [1:0] WB_PC   = 2'd3;

   localparam logic [1:0] BE_NONE = 2'd0;
   localparam logic [1:0] BE_BYTE = 2'd1;
   localparam logic [1:0] BE_HALF = 2'd2;
   localparam logic [1:0] BE_WORD = 2'd3;

   typedef struct packed {
      logic       pc_sel;
      logic       op1_sel;
      logic       op2_sel;
      logic [3:0] alu_op;
      logic       rf_wr_en;
      logic [1:0] rf_wr_data_sel;
      logic       dmem_req;
      logic       dmem_wr_en;
      logic [1:0] dmem_byte_en;
      logic       dmem_zero_extend;
   } control_t;

endpackage

module sparrow_decode_stage #(
   parameter int XLEN  = 32,
   parameter bit EN_M  = 1'b1,
   parameter int DEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [31:0]                i_instr,
   input  logic [XLEN-1:0]            i_pc,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [31:0]                o_instr,
   output logic [XLEN-1:0]            o_pc,
   output sparrow_pkg::control_t      o_controls,
   output logic [4:0]                 o_rs1,
   output logic [4:0]                 o_rs2,
   output logic [4:0]                 o_rd,
   output logic                       o_m_en,
   output logic [2:0]                 o_m_op,
   output logic                       o_illegal,
   output logic [$clog2(DEPTH):0]     o_count
);
   import sparrow_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      control_t        controls;
      logic            m_en;
      logic [2:0]      m_op;
      logic            illegal;
   } entry_t;

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   control_t        w_ctrl;
   logic            w_m_en;
   logic [2:0]      w_m_op;
   logic            w_illegal;
   entry_t          w_entry;
   entry_t          w_head;
   entry_t          w_slots [DEPTH];
   logic            w_push;
   logic            w_pop;

   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   assign w_funct7 = i_instr[31:25];

   // Loads and stores share the funct3[1:0] size encoding.
   function automatic logic [1:0] size_to_be(input logic [1:0] size);
      logic [1:0] be;
      case (size)
         2'b00:   be = BE_BYTE;
         2'b01:   be = BE_HALF;
         2'b10:   be = BE_WORD;
         default: be = BE_NONE;
      endcase
      return be;
   endfunction

   always_comb begin
      w_ctrl    = '0;
      w_m_en    = 1'b0;
      w_m_op    = 3'b000;
      w_illegal = 1'b0;
      case (w_opcode)
         OPC_R: begin
            if (w_funct7 == F7_MULDIV) begin
               if (EN_M) begin
                  w_m_en          = 1'b1;
                  w_m_op          = w_funct3;
                  w_ctrl.rf_wr_en = 1'b1;
                  w_ctrl.alu_op   = OP_ADD;
               end else begin
                  w_illegal = 1'b1;
               end
            end else begin
               w_ctrl.rf_wr_en       = 1'b1;
               w_ctrl.rf_wr_data_sel = WB_ALU;
               w_ctrl.alu_op         = {w_funct7[5], w_funct3};
               if (w_funct7 != F7_BASE && w_funct7 != F7_ALT) begin
                  w_illegal = 1'b1;
               end else if (w_funct7 == F7_ALT && w_funct3 != 3'b000 && w_funct3 != 3'b101) begin
                  w_illegal = 1'b1;
               end
            end
         end
         OPC_IMM: begin
            w_ctrl.rf_wr_en = 1'b1;
            w_ctrl.op2_sel  = 1'b1;
            w_ctrl.alu_op   = {1'b0, w_funct3};
            // Only the shift-immediates constrain funct7; funct7[5] picks SRAI.
            if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
               if (w_funct7 != F7_BASE && w_funct7 != F7_ALT) begin
                  w_illegal = 1'b1;
               end
               if (w_funct3 == 3'b001 && w_funct7 == F7_ALT) begin
                  w_illegal = 1'b1;
               end
               if (w_funct3 == 3'b101) begin
                  w_ctrl.alu_op = {w_funct7[5], w_funct3};
               end
            end
         end
         OPC_LOAD: begin
            w_ctrl.rf_wr_en         = 1'b1;
            w_ctrl.op2_sel          = 1'b1;
            w_ctrl.dmem_req         = 1'b1;
            w_ctrl.rf_wr_data_sel   = WB_MEM;
            w_ctrl.dmem_byte_en     = size_to_be(w_funct3[1:0]);
            w_ctrl.dmem_zero_extend = w_funct3[2];
            if (w_funct3[1:0] == 2'b11 || w_funct3 == 3'b110) begin
               w_illegal = 1'b1;
            end
         end
         OPC_JALR: begin
            w_ctrl.rf_wr_en       = 1'b1;
            w_ctrl.op2_sel        = 1'b1;
            w_ctrl.pc_sel         = 1'b1;
            w_ctrl.rf_wr_data_sel = WB_PC;
            w_ctrl.alu_op         = OP_ADD;
            w_ctrl.dmem_req       = 1'b0;
            w_ctrl.dmem_byte_en   = BE_NONE;
            if (w_funct3 != 3'b000) begin
               w_illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            w_ctrl.dmem_req     = 1'b1;
            w_ctrl.dmem_wr_en   = 1'b1;
            w_ctrl.op2_sel      = 1'b1;
            w_ctrl.dmem_byte_en = size_to_be(w_funct3[1:0]);
            if (w_funct3 > 3'b010) begin
               w_illegal = 1'b1;
            end
         end
         OPC_BRANCH: begin
            w_ctrl.op1_sel = 1'b1;
            w_ctrl.op2_sel = 1'b1;
            w_ctrl.alu_op  = OP_ADD;
            if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
               w_illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            w_ctrl.rf_wr_en       = 1'b1;
            w_ctrl.rf_wr_data_sel = WB_IMM;
         end
         OPC_AUIPC: begin
            w_ctrl.rf_wr_en = 1'b1;
            w_ctrl.op1_sel  = 1'b1;
            w_ctrl.op2_sel  = 1'b1;
         end
         OPC_JAL: begin
            w_ctrl.rf_wr_en       = 1'b1;
            w_ctrl.rf_wr_data_sel = WB_PC;
            w_ctrl.op1_sel        = 1'b1;
            w_ctrl.op2_sel        = 1'b1;
            w_ctrl.pc_sel         = 1'b1;
         end
         OPC_FENCE: begin
            w_ctrl = '0;
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
      if (i_instr[1:0] != 2'b11) begin
         w_illegal = 1'b1;
      end
      // Illegal entries travel with clean controls so execute never acts on them.
      if (w_illegal) begin
         w_ctrl = '0;
         w_m_en = 1'b0;
         w_m_op = 3'b000;
      end
   end

   assign w_entry = '{instr: i_instr, pc: i_pc, controls: w_ctrl,
                      m_en: w_m_en, m_op: w_m_op, illegal: w_illegal};

   assign o_ready = (r_count < FULL_COUNT);
   assign o_valid = (r_count != '0);
   assign w_push  = i_valid && o_ready && !i_flush;
   assign w_pop   = o_valid && i_ready;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         entry_t r_slot;
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_slot <= '0;
            end else if (w_push && r_wr_ptr == PW'(gi)) begin
               r_slot <= w_entry;
            end
         end
         assign w_slots[gi] = r_slot;
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Stale slot contents are masked so an empty stage presents all zeros.
   assign w_head     = o_valid ? w_slots[r_rd_ptr] : '0;
   assign o_instr    = w_head.instr;
   assign o_pc       = w_head.pc;
   assign o_controls = w_head.controls;
   assign o_rs1      = w_head.instr[19:15];
   assign o_rs2      = w_head.instr[24:20];
   assign o_rd       = w_head.instr[11:7];
   assign o_m_en     = w_head.m_en;
   assign o_m_op     = w_head.m_op;
   assign o_illegal  = w_head.illegal;
   assign o_count    = r_count;

endmodule

// File: tb/tb_sparrow_decode_stage.sv
// Scoreboard bench for sparrow_decode_stage: two instances (EN_M=1 and EN_M=0)
// share one stimulus stream and are checked against a rule-level decode model.
module tb_sparrow_decode_stage;
   import sparrow_pkg::*;

   localparam int DEPTH = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        valid = 1'b0;
   logic        ready = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] pc    = '0;

   logic        a_ready, a_valid, a_m_en, a_ill;
   logic [31:0] a_instr, a_pc;
   control_t    a_ctrl;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [2:0]  a_m_op;
   logic [1:0]  a_count;

   logic        b_ready, b_valid, b_m_en, b_ill;
   logic [31:0] b_instr, b_pc;
   control_t    b_ctrl;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [2:0]  b_m_op;
   logic [1:0]  b_count;

   always #5 clk = ~clk;

   sparrow_decode_stage #(.XLEN(32), .EN_M(1'b1), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(a_ready),
      .i_instr(instr), .i_pc(pc), .o_valid(a_valid), .i_ready(ready), .o_instr(a_instr),
      .o_pc(a_pc), .o_controls(a_ctrl), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_rd(a_rd),
      .o_m_en(a_m_en), .o_m_op(a_m_op), .o_illegal(a_ill), .o_count(a_count));

   sparrow_decode_stage #(.XLEN(32), .EN_M(1'b0), .DEPTH(DEPTH)) dut_nom (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(b_ready),
      .i_instr(instr), .i_pc(pc), .o_valid(b_valid), .i_ready(ready), .o_instr(b_instr),
      .o_pc(b_pc), .o_controls(b_ctrl), .o_rs1(b_rs1), .o_rs2(b_rs2), .o_rd(b_rd),
      .o_m_en(b_m_en), .o_m_op(b_m_op), .o_illegal(b_ill), .o_count(b_count));

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } txn_t;

   typedef struct packed {
      control_t   c;
      logic       m_en;
      logic [2:0] m_op;
      logic       ill;
   } dec_t;

   txn_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Decode rules stated instruction-class by instruction-class.
   function automatic dec_t model(input logic [31:0] x, input bit en_m);
      dec_t       d;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      bit         ill;
      d  = '0;
      op = x[6:0];
      f3 = x[14:12];
      f7 = x[31:25];
      ill = 1'b0;
      if (x[1:0] != 2'b11) begin
         ill = 1'b1;
      end else if (op == 7'h33) begin
         if (f7 == 7'h01) begin
            if (en_m) begin
               d.m_en = 1'b1; d.m_op = f3; d.c.rf_wr_en = 1'b1; d.c.alu_op = OP_ADD;
            end else ill = 1'b1;
         end else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
            d.c.rf_wr_en = 1'b1; d.c.alu_op = {f7[5], f3};
         end else ill = 1'b1;
      end else if (op == 7'h13) begin
         d.c.rf_wr_en = 1'b1; d.c.op2_sel = 1'b1; d.c.alu_op = {1'b0, f3};
         if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
         if (f3 == 3'd5) begin
            if (f7 == 7'h20) d.c.alu_op = 4'b1101;
            else if (f7 != 7'h00) ill = 1'b1;
         end
      end else if (op == 7'h03) begin
         d.c.rf_wr_en = 1'b1; d.c.op2_sel = 1'b1; d.c.dmem_req = 1'b1; d.c.rf_wr_data_sel = WB_MEM;
         case (f3)
            3'd0: d.c.dmem_byte_en = BE_BYTE;
            3'd1: d.c.dmem_byte_en = BE_HALF;
            3'd2: d.c.dmem_byte_en = BE_WORD;
            3'd4: begin d.c.dmem_byte_en = BE_BYTE; d.c.dmem_zero_extend = 1'b1; end
            3'd5: begin d.c.dmem_byte_en = BE_HALF; d.c.dmem_zero_extend = 1'b1; end
            default: ill = 1'b1;
         endcase
      end else if (op == 7'h67) begin
         d.c.rf_wr_en = 1'b1; d.c.op2_sel = 1'b1; d.c.pc_sel = 1'b1; d.c.rf_wr_data_sel = WB_PC;
         if (f3 != 3'd0) ill = 1'b1;
      end else if (op == 7'h23) begin
         d.c.dmem_req = 1'b1; d.c.dmem_wr_en = 1'b1; d.c.op2_sel = 1'b1;
         case (f3)
            3'd0: d.c.dmem_byte_en = BE_BYTE;
            3'd1: d.c.dmem_byte_en = BE_HALF;
            3'd2: d.c.dmem_byte_en = BE_WORD;
            default: ill = 1'b1;
         endcase
      end else if (op == 7'h63) begin
         d.c.op1_sel = 1'b1; d.c.op2_sel = 1'b1;
         if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
      end else if (op == 7'h37) begin
         d.c.rf_wr_en = 1'b1; d.c.rf_wr_data_sel = WB_IMM;
      end else if (op == 7'h17) begin
         d.c.rf_wr_en = 1'b1; d.c.op1_sel = 1'b1; d.c.op2_sel = 1'b1;
      end else if (op == 7'h6F) begin
         d.c.rf_wr_en = 1'b1; d.c.rf_wr_data_sel = WB_PC; d.c.op1_sel = 1'b1;
         d.c.op2_sel = 1'b1; d.c.pc_sel = 1'b1;
      end else if (op != 7'h0F) begin
         ill = 1'b1;
      end
      if (ill) d = '0;
      d.ill = ill;
      return d;
   endfunction

   function automatic logic [127:0] exp_head(input txn_t t, input bit en_m);
      dec_t d;
      d = model(t.instr, en_m);
      return 128'({t.instr, t.pc, d.c, t.instr[19:15], t.instr[24:20], t.instr[11:7],
                   d.m_en, d.m_op, d.ill});
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 12))
         0:  x[6:0] = 7'h33;
         1:  x[6:0] = 7'h13;
         2:  x[6:0] = 7'h03;
         3:  x[6:0] = 7'h67;
         4:  x[6:0] = 7'h23;
         5:  x[6:0] = 7'h63;
         6:  x[6:0] = 7'h37;
         7:  x[6:0] = 7'h17;
         8:  x[6:0] = 7'h6F;
         9:  x[6:0] = 7'h0F;
         10: x[6:0] = 7'h73;
         default: ;
      endcase
      case ($urandom_range(0, 3))
         0: x[31:25] = 7'h00;
         1: x[31:25] = 7'h20;
         2: x[31:25] = 7'h01;
         default: ;
      endcase
      if ($urandom_range(0, 15) == 0) x[1:0] = 2'($urandom);
      return x;
   endfunction

   // Stimulus side: record every accepted instruction.
   always @(negedge clk) begin
      if (rst_n && valid && a_ready && !flush) sbq.push_back('{instr: instr, pc: pc});
   end

   // Monitor: compares head and occupancy against the scoreboard each cycle.
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         sbq.delete();
      end else begin
         chk("count_a", 128'(a_count), 128'(sbq.size()));
         chk("count_b", 128'(b_count), 128'(sbq.size()));
         if (a_valid && sbq.size() > 0) begin
            chk("head_a", 128'({a_instr, a_pc, a_ctrl, a_rs1, a_rs2, a_rd, a_m_en, a_m_op, a_ill}),
                exp_head(sbq[0], 1'b1));
            chk("head_b", 128'({b_instr, b_pc, b_ctrl, b_rs1, b_rs2, b_rd, b_m_en, b_m_op, b_ill}),
                exp_head(sbq[0], 1'b0));
            if (ready && !flush) begin
               $display("pop pc=%08h instr=%08h ill_a=%0d ill_b=%0d", a_pc, a_instr, a_ill, b_ill);
               void'(sbq.pop_front());
            end
         end
         if (flush) sbq.delete();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] p);
      bit ok;
      ok    = 1'b0;
      valid = 1'b1;
      instr = x;
      pc    = p;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = a_ready;
         tick();
      end
      valid = 1'b0;
      if (!ok) chk("send_timeout", 128'(0), 128'(1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      ready = 1'b1;
      while (a_count != 0 && n < 40) begin
         tick();
         n++;
      end
      chk("drain_empty", 128'(a_count), 128'(0));
   endtask

   initial begin
      bit done;
      bit acc;
      // Reset state
      repeat (2) tick();
      chk("rst_valid", 128'(a_valid), 128'(0));
      chk("rst_count", 128'(a_count), 128'(0));
      chk("rst_ready", 128'(a_ready), 128'(1));
      chk("rst_head", 128'({a_instr, a_pc, a_ctrl, a_rs1, a_rs2, a_rd, a_m_en, a_m_op, a_ill}), 128'(0));
      #2 rst_n = 1'b1;
      tick();

      // ADD x3,x1,x2
      ready = 1'b1;
      send(32'h002081B3, 32'h100);
      chk("add_valid", 128'(a_valid), 128'(1));
      chk("add_wr", 128'(a_ctrl.rf_wr_en), 128'(1));
      chk("add_alu", 128'(a_ctrl.alu_op), 128'(OP_ADD));
      chk("add_regs", 128'({a_rs1, a_rs2, a_rd}), 128'({5'd1, 5'd2, 5'd3}));
      chk("add_pc", 128'(a_pc), 128'(32'h100));
      chk("add_ill", 128'(a_ill), 128'(0));

      // JALR x1,0(x5)
      send(32'h000280E7, 32'h104);
      chk("jalr_ctl", 128'({a_ctrl.pc_sel, a_ctrl.rf_wr_data_sel, a_ctrl.op2_sel,
                            a_ctrl.dmem_req, a_ctrl.dmem_byte_en}),
          128'({1'b1, WB_PC, 1'b1, 1'b0, BE_NONE}));

      // MUL with and without RV32M
      send(32'h022081B3, 32'h108);
      chk("mul_m", 128'({a_m_en, a_m_op, a_ctrl.rf_wr_en, a_ill}), 128'({1'b1, 3'b000, 1'b1, 1'b0}));
      chk("mul_nom", 128'({b_ill, b_ctrl, b_m_en}), 128'({1'b1, 15'd0, 1'b0}));
      tick();

      // Fill to DEPTH with execute stalled, third instruction held off
      ready = 1'b0;
      send(32'h002081B3, 32'h200);
      send(32'h000280E7, 32'h204);
      valid = 1'b1;
      instr = 32'h12345237;
      pc    = 32'h208;
      tick();
      tick();
      chk("full_ready", 128'(a_ready), 128'(0));
      chk("full_count", 128'(a_count), 128'(2));
      chk("full_head", 128'(a_pc), 128'(32'h200));
      ready = 1'b1;
      tick();
      chk("pop1_ready", 128'(a_ready), 128'(1));
      chk("pop1_head", 128'({a_count, a_pc}), 128'({2'd1, 32'h204}));
      tick();
      chk("pushpop_count", 128'({a_count, a_pc}), 128'({2'd1, 32'h208}));
      valid = 1'b0;
      tick();
      chk("drained", 128'({a_count, a_valid}), 128'(0));

      // Flush with a full FIFO and a simultaneous LBU
      ready = 1'b0;
      send(32'h002081B3, 32'h300);
      send(32'h002081B3, 32'h304);
      flush = 1'b1; valid = 1'b1; instr = 32'h00034283; pc = 32'h308;
      tick();
      flush = 1'b0; valid = 1'b0;
      chk("flush_full", 128'({a_valid, a_count}), 128'(0));
      tick();
      chk("flush_drop", 128'({a_valid, a_count}), 128'(0));

      // Flush with room: the push in the flush cycle must still be dropped
      send(32'h002081B3, 32'h310);
      flush = 1'b1; valid = 1'b1; instr = 32'h00034283; pc = 32'h314;
      tick();
      flush = 1'b0; valid = 1'b0;
      chk("flush_room", 128'({a_valid, a_count}), 128'(0));

      // Illegal all-ones, then LBU x5,0(x6)
      send(32'hFFFFFFFF, 32'h400);
      chk("ones_ill", 128'({a_ill, a_ctrl, a_m_en}), 128'({1'b1, 15'd0, 1'b0}));
      drain();
      ready = 1'b0;
      send(32'h00034283, 32'h404);
      chk("lbu_ctl", 128'({a_ctrl.dmem_req, a_ctrl.dmem_byte_en, a_ctrl.rf_wr_data_sel,
                           a_ctrl.dmem_zero_extend, a_ctrl.rf_wr_en, a_rd, a_ill}),
          128'({1'b1, BE_BYTE, WB_MEM, 1'b1, 1'b1, 5'd5, 1'b0}));
      drain();

      // Randomised traffic with stalls and occasional flushes
      done = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (done) begin
            valid = ($urandom_range(0, 2) != 0);
            instr = rand_instr();
            pc    = pc + 32'd4;
         end
         ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         acc  = valid && a_ready;
         done = !valid || acc || flush;
         tick();
      end
      valid = 1'b0;
      flush = 1'b0;
      drain();

      // Asynchronous reset in the middle of traffic
      ready = 1'b0;
      send(32'h002081B3, 32'h500);
      send(32'h00034283, 32'h504);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_a", 128'({a_valid, a_count, a_instr, a_pc, a_ctrl, a_m_en, a_ill}), 128'(0));
      chk("async_rst_b", 128'({b_valid, b_count}), 128'(0));
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      ready = 1'b1;
      send(32'h022081B3, 32'h600);
      send(32'h00000073, 32'h604);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
